// File: rtl/vedio_src_sched.sv
// vedio_src_sched: frame-boundary scheduler driving a video source's image select
// Ports: clk/rst (sync, active-high); cfg_start/cfg_stop pulses; cfg_loop, cfg_first,
// cfg_last, cfg_nframes playlist config; src_vsync in; src_sel, sched_busy, sched_done,
// frame_tick, frame_cnt, sched_err out. Define VSRC_SCHED_WATCHDOG_EN for the vsync watchdog.
module vedio_src_sched #(
  parameter int SEL_W       = 4,
  parameter int FCNT_W      = 8,
  parameter bit VS_POL      = 1'b1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_loop,
  input  logic [SEL_W-1:0]  cfg_first,
  input  logic [SEL_W-1:0]  cfg_last,
  input  logic [FCNT_W-1:0] cfg_nframes,
  input  logic              src_vsync,
  output logic [SEL_W-1:0]  src_sel,
  output logic              sched_busy,
  output logic              sched_done,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              sched_err
);
  typedef enum logic [1:0] {IDLE, ARM, PLAY, DRAIN} state_t;
  state_t state, state_nx;
  logic vs_r, fs, timeout;
  logic loop_q, loop_nx, done_nx, tick_nx, err_nx;
  logic [SEL_W-1:0] first_q, first_nx, last_q, last_nx, sel_nx;
  logic [FCNT_W-1:0] nfr_q, nfr_nx, cnt_nx;
  assign fs = (src_vsync == VS_POL) && (vs_r != VS_POL);
  assign sched_busy = (state != IDLE);
`ifdef VSRC_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  assign timeout = (state != IDLE) && !fs && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || fs) wd_q <= '0;
    else wd_q <= wd_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    sel_nx   = src_sel;
    cnt_nx   = frame_cnt;
    done_nx  = 1'b0;
    tick_nx  = 1'b0;
    err_nx   = sched_err;
    loop_nx  = loop_q;
    first_nx = first_q;
    last_nx  = last_q;
    nfr_nx   = nfr_q;
    case (state)
      IDLE: if (cfg_start) begin
        state_nx = ARM;
        loop_nx  = cfg_loop;
        first_nx = cfg_first;
        last_nx  = cfg_last;
        nfr_nx   = (cfg_nframes == '0) ? FCNT_W'(1) : cfg_nframes;
        sel_nx   = cfg_first;
        cnt_nx   = '0;
        err_nx   = 1'b0;
      end
      ARM: if (cfg_stop) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else if (fs) begin
        state_nx = PLAY;
        cnt_nx   = FCNT_W'(1);
        tick_nx  = 1'b1;
      end
      PLAY: if (fs) begin
        if (frame_cnt >= nfr_q && src_sel == last_q && !loop_q) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = cfg_stop ? DRAIN : PLAY;
          tick_nx  = 1'b1;
          cnt_nx   = (frame_cnt < nfr_q) ? frame_cnt + 1'b1 : FCNT_W'(1);
          sel_nx   = (frame_cnt < nfr_q) ? src_sel : (src_sel != last_q) ? src_sel + 1'b1 : first_q;
        end
      end else if (cfg_stop) state_nx = DRAIN;
      DRAIN: if (fs) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (timeout) begin
      state_nx = IDLE;
      done_nx  = 1'b1;
      tick_nx  = 1'b0;
      err_nx   = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vs_r       <= VS_POL;
      src_sel    <= '0;
      frame_cnt  <= '0;
      sched_done <= 1'b0;
      frame_tick <= 1'b0;
      sched_err  <= 1'b0;
      loop_q     <= 1'b0;
      first_q    <= '0;
      last_q     <= '0;
      nfr_q      <= FCNT_W'(1);
    end else begin
      state      <= state_nx;
      vs_r       <= src_vsync;
      src_sel    <= sel_nx;
      frame_cnt  <= cnt_nx;
      sched_done <= done_nx;
      frame_tick <= tick_nx;
      sched_err  <= err_nx;
      loop_q     <= loop_nx;
      first_q    <= first_nx;
      last_q     <= last_nx;
      nfr_q      <= nfr_nx;
    end
  end
endmodule

// File: tb/tb_vedio_src_sched.sv
// tb_vedio_src_sched: playlist-level model plus directed scenarios for vedio_src_sched
module tb_vedio_src_sched;
  localparam int SEL_W = 4, FCNT_W = 8, TO = 100;
  logic clk = 0, rst = 1, cfg_start = 0, cfg_stop = 0, cfg_loop = 0, src_vsync = 0;
  logic [SEL_W-1:0] cfg_first = 0, cfg_last = 0;
  logic [FCNT_W-1:0] cfg_nframes = 0;
  logic [SEL_W-1:0] src_sel;
  logic [FCNT_W-1:0] frame_cnt;
  logic sched_busy, sched_done, frame_tick, sched_err;
  int tests = 0, fails = 0, n_tick = 0, n_done = 0;
  always #5 clk = ~clk;
  vedio_src_sched #(.SEL_W(SEL_W), .FCNT_W(FCNT_W), .VS_POL(1'b1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_loop(cfg_loop),
    .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_nframes(cfg_nframes), .src_vsync(src_vsync),
    .src_sel(src_sel), .sched_busy(sched_busy), .sched_done(sched_done), .frame_tick(frame_tick),
    .frame_cnt(frame_cnt), .sched_err(sched_err));
  // Playlist model: the k-th counted frame of a schedule is fully determined by k
  int m_phase = 0, m_k = 0, m_first = 0, m_len = 1, m_n = 1, m_wd = 0;
  bit m_loop = 0, m_prev = 1;
  logic [SEL_W-1:0] e_sel = 0;
  logic [FCNT_W-1:0] e_cnt = 0;
  logic e_done = 0, e_tick = 0, e_err = 0;
  function automatic logic [SEL_W-1:0] sel_of(int k, int first, int n, int len);
    return SEL_W'(first + ((k - 1) / n) % len);
  endfunction
  always @(posedge clk) begin
    bit fs, to;
    fs = src_vsync && !m_prev;
    m_prev = src_vsync;
    to = 0;
    e_done = 0;
    e_tick = 0;
    if (rst) begin
      m_phase = 0; m_prev = 1; e_sel = 0; e_cnt = 0; e_err = 0;
    end else begin
`ifdef VSRC_SCHED_WATCHDOG_EN
      if (m_phase != 0) begin
        if (fs) m_wd = 0;
        else if (m_wd == TO - 1) begin to = 1; m_phase = 0; e_done = 1; e_err = 1; end
        else m_wd++;
      end
`endif
      if (!to) case (m_phase)
        0: if (cfg_start) begin
          m_first = int'(cfg_first);
          m_len = ((int'(cfg_last) - int'(cfg_first) + 16) % 16) + 1;
          m_n = (cfg_nframes == 0) ? 1 : int'(cfg_nframes);
          m_loop = cfg_loop; m_k = 0; m_wd = 0;
          e_sel = cfg_first; e_cnt = 0; e_err = 0; m_phase = 1;
        end
        1: if (cfg_stop) begin e_done = 1; m_phase = 0; end
           else if (fs) begin m_k = 1; e_tick = 1; e_sel = sel_of(1, m_first, m_n, m_len); e_cnt = 1; m_phase = 2; end
        2: if (fs) begin
             if (!m_loop && m_k == m_n * m_len) begin e_done = 1; m_phase = 0; end
             else begin
               m_k++; e_tick = 1;
               e_sel = sel_of(m_k, m_first, m_n, m_len);
               e_cnt = FCNT_W'((m_k - 1) % m_n + 1);
               if (cfg_stop) m_phase = 3;
             end
           end else if (cfg_stop) m_phase = 3;
        3: if (fs) begin e_done = 1; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(negedge clk);
    chk("src_sel", src_sel, e_sel);
    chk("frame_cnt", frame_cnt, e_cnt);
    chk("busy", sched_busy, m_phase != 0);
    chk("done", sched_done, e_done);
    chk("tick", frame_tick, e_tick);
    chk("err", sched_err, e_err);
    if (frame_tick) n_tick++;
    if (sched_done) n_done++;
  endtask
  task automatic cyc(int n);
    repeat (n) step();
  endtask
  task automatic frames(int n, int per);
    repeat (n) begin
      src_vsync = 1; cyc(2);
      src_vsync = 0; cyc(per - 2);
    end
  endtask
  task automatic start(int f, int l, int n, bit lp);
    cfg_first = SEL_W'(f); cfg_last = SEL_W'(l); cfg_nframes = FCNT_W'(n); cfg_loop = lp;
    cfg_start = 1; cyc(1); cfg_start = 0;
  endtask
  task automatic stop();
    cfg_stop = 1; cyc(1); cfg_stop = 0;
  endtask
  initial begin
    int t0, d0;
    cyc(3);
    chk("rst_sel", src_sel, 0);
    chk("rst_busy", sched_busy, 0);
    rst = 0; cyc(2);
    t0 = n_tick; d0 = n_done;
    start(1, 1, 2, 0); frames(3, 8);
    chk("t1_ticks", n_tick - t0, 2);
    chk("t1_done", n_done - d0, 1);
    chk("t1_sel", src_sel, 1);
    chk("t1_cnt", frame_cnt, 2);
    chk("t1_busy", sched_busy, 0);
    t0 = n_tick; d0 = n_done;
    start(0, 2, 1, 0); frames(4, 6);
    chk("t2_ticks", n_tick - t0, 3);
    chk("t2_done", n_done - d0, 1);
    chk("t2_sel", src_sel, 2);
    d0 = n_done;
    start(14, 1, 1, 1); frames(10, 5);
    chk("t3_sel", src_sel, 15);
    chk("t3_busy", sched_busy, 1);
    chk("t3_done", n_done - d0, 0);
    stop(); cyc(3);
    chk("t3_drain_sel", src_sel, 15);
    frames(1, 5);
    chk("t3_end_busy", sched_busy, 0);
    d0 = n_done;
    start(2, 5, 1, 0); frames(2, 6); cyc(1);
    stop(); cyc(2);
    chk("t4_hold_sel", src_sel, 3);
    chk("t4_no_done", n_done - d0, 0);
    frames(1, 6);
    chk("t4_done", n_done - d0, 1);
    chk("t4_sel", src_sel, 3);
    start(4, 6, 1, 0); cyc(2);
    stop();
    chk("t5_done", sched_done, 1);
    chk("t5_busy", sched_busy, 0);
    cyc(1);
    d0 = n_done;
    start(3, 4, 1, 0); frames(1, 6);
    start(9, 12, 3, 1); frames(2, 6);
    chk("t6_sel", src_sel, 4);
    chk("t6_done", n_done - d0, 1);
    t0 = n_tick; d0 = n_done;
    start(5, 6, 0, 0); frames(3, 6);
    chk("t7_ticks", n_tick - t0, 2);
    chk("t7_sel", src_sel, 6);
    chk("t7_cnt", frame_cnt, 1);
    d0 = n_done;
    start(7, 7, 4, 1); frames(2, 6);
    rst = 1; step(); rst = 0;
    chk("t8_sel", src_sel, 0);
    chk("t8_cnt", frame_cnt, 0);
    chk("t8_busy", sched_busy, 0);
    chk("t8_done", n_done - d0, 0);
    cyc(2);
`ifdef VSRC_SCHED_WATCHDOG_EN
    start(1, 2, 1, 0); cyc(99);
    chk("wd_err_early", sched_err, 0);
    cyc(1);
    chk("wd_err", sched_err, 1);
    chk("wd_done", sched_done, 1);
    chk("wd_busy", sched_busy, 0);
    cyc(2);
    start(1, 2, 1, 0);
    chk("wd_clear", sched_err, 0);
    stop(); cyc(2);
`else
    chk("err_const", sched_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
